// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative RV M-extension multiply/divide unit:
// op encodings, FSM state enum and operand-signedness helpers.
package alu_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_signed_s1(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_s2(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider on a 2*XLEN
// accumulator. Divide path is present only when ALU_MULDIV_DIV_EN is defined.
module alu_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic              is_div_i,
  output logic [2*XLEN-1:0] acc_o
);

  // Multiply: acc = {partial_hi, multiplier_lo}; add multiplicand on lo[0], shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;

  always_comb begin
    mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    mul_acc = {mul_sum, acc_i[XLEN-1:1]};
  end

`ifdef ALU_MULDIV_DIV_EN
  // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_acc;

  always_comb begin
    div_sh   = acc_i[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, opnd_i};
    if (div_diff[XLEN]) begin
      div_acc = {div_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end else begin
      div_acc = {div_diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end
  end

  assign acc_o = is_div_i ? div_acc : mul_acc;
`else
  assign acc_o = is_div_i ? acc_i : mul_acc;
`endif

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV M-extension multiply/divide unit (one bit per cycle) with
// valid/ready in and out. Divide support is built only with ALU_MULDIV_DIV_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; ready/valid depend only on the FSM state, the producer holds its data
// until the transfer, and kill drops any in-flight op (result discarded).
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int XLEN = 32  // >= 8, power of two
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] s1,
  input  logic [XLEN-1:0] s2,
  input  logic [2:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output state_e          dbg_state
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   dvs_q;
  logic [XLEN-1:0]   out_q;
  logic [2:0]        op_q;
  logic              neg_q;

  logic              neg1_d;
  logic              neg2_d;
  logic [XLEN-1:0]   mag1_d;
  logic [XLEN-1:0]   mag2_d;
  logic              rneg_d;
  logic              special_d;
  logic [XLEN-1:0]   special_res_d;
  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res_d;

  always_comb begin
    neg1_d = is_signed_s1(op) & s1[XLEN-1];
    neg2_d = is_signed_s2(op) & s2[XLEN-1];
    mag1_d = neg1_d ? -s1 : s1;
    mag2_d = neg2_d ? -s2 : s2;
    // Remainder follows the dividend's sign; products and quotients the sign XOR.
    rneg_d = (op[2] & op[1]) ? neg1_d : (neg1_d ^ neg2_d);
  end

`ifdef ALU_MULDIV_DIV_EN
  always_comb begin
    special_d     = 1'b0;
    special_res_d = '0;
    if (op[2]) begin
      if (s2 == '0) begin
        special_d     = 1'b1;
        special_res_d = op[1] ? s1 : '1;
      end else if (!op[0] && (s1 == {1'b1, {(XLEN-1){1'b0}}}) && (s2 == '1)) begin
        special_d     = 1'b1;
        special_res_d = op[1] ? '0 : s1;
      end
    end
  end
`else
  always_comb begin
    special_d     = op[2];
    special_res_d = '0;
  end
`endif

  alu_muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .acc_i   (acc_q),
    .opnd_i  (dvs_q),
    .is_div_i(op_q[2]),
    .acc_o   (step_acc)
  );

  always_comb begin
    prod  = neg_q ? -step_acc : step_acc;
    res_d = '0;
    case (op_q)
      OP_MUL:                       res_d = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod[2*XLEN-1:XLEN];
`ifdef ALU_MULDIV_DIV_EN
      OP_DIV, OP_DIVU: res_d = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
      OP_REM, OP_REMU: res_d = neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
`endif
      default:                      res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      out_q   <= '0;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
    end else if (kill && (state_q != IDLE)) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && !kill) begin
            op_q  <= op;
            neg_q <= rneg_d;
            acc_q <= {{XLEN{1'b0}}, mag1_d};
            dvs_q <= mag2_d;
            cnt_q <= CNT_LAST;
            if (special_d) begin
              out_q   <= special_res_d;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= step_acc;
          // The last step's result is fixed up straight into the output register.
          if (cnt_q == '0) begin
            out_q   <= res_d;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed corner ops, backpressure, kill/reset aborts,
// then randomized ops against a plain-arithmetic reference model.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kill = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] s1_i = '0;
  logic [31:0] s2_i = '0;
  logic [2:0]  op_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  state_e      dbg_state;

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .kill     (kill),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s1       (s1_i),
    .s2       (s2_i),
    .op       (op_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .dbg_state(dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_cyc = 0;
  int          issued = 0;
  int          flushed = 0;
  int          done_n = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
`ifdef ALU_MULDIV_DIV_EN
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      3'd7: return (b == 0) ? a : a % b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_MULDIV_DIV_EN
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
`else
    return o[2] ? 1 : XLEN + 1;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Driver tasks
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
    op_i = o; s1_i = a; s2_i = b; in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    issued++;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd_ready);
    int n = 0;
    do begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end while (!in_ready && n < 300);
    out_ready = 1'b1;
    if (!in_ready) chk("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic flush_last();
    void'(exp_q.pop_back());
    if (lat_q.size() > 0) void'(lat_q.pop_back());
    flushed++;
  endtask

  // Monitor / scoreboard
  bit          vld_prev = 0, hs_prev = 0, kill_prev = 0, hs;
  logic [31:0] out_prev = '0;

  always @(negedge clk) begin
    hs = 1'b0;
    if (!rst) begin
      if (issued != done_n + flushed) chk("busy_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && !vld_prev) begin
        if (lat_q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - acc_cyc + 1), 32'(lat_q.pop_front()));
      end
      if (vld_prev && !hs_prev && !kill_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_out", out, out_prev);
      end
      if (hs_prev) begin
        chk("idle_after_hs_ready", 32'(in_ready), 32'd1);
        chk("idle_after_hs_valid", 32'(out_valid), 32'd0);
      end
      hs = out_valid && out_ready && !kill;
      if (hs) begin
        if (exp_q.size() == 0) chk("result_unexpected", 32'd1, 32'd0);
        else chk("result", out, exp_q.pop_front());
        done_n++;
      end
    end
    vld_prev  = out_valid && !rst;
    hs_prev   = hs;
    kill_prev = kill;
    out_prev  = out;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // Main sequence
  initial begin
    int n;
    int seen;
    logic [2:0]  o;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33); wait_idle(0);
    issue(OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33); wait_idle(0);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33); wait_idle(0);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33); wait_idle(0);
`ifdef ALU_MULDIV_DIV_EN
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33); wait_idle(0);
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33); wait_idle(0);
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 33); wait_idle(0);
    issue(OP_REMU, 32'd100, 32'd7, 32'd2, 33); wait_idle(0);
    issue(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1); wait_idle(0);
    issue(OP_REM, 32'd5, 32'd0, 32'd5, 1); wait_idle(0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); wait_idle(0);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1); wait_idle(0);
`else
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 1); wait_idle(0);
    issue(OP_REMU, 32'd100, 32'd7, 32'd0, 1); wait_idle(0);
`endif

    // Backpressure: result held for 5 stalled cycles
    out_ready = 1'b0;
    issue(OP_MUL, 32'h1234_5678, 32'h0000_0100, 32'h3456_7800, 33);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_valid_reached", 32'(out_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_out_held", out, 32'h3456_7800);
    out_ready = 1'b1;
    wait_idle(0);

    // kill in IDLE must not accept a coincident in_valid
    kill = 1'b1; in_valid = 1'b1; op_i = OP_MUL; s1_i = 32'd3; s2_i = 32'd3;
    @(posedge clk); #1;
    chk("kill_idle_ready", 32'(in_ready), 32'd1);
    chk("kill_idle_valid", 32'(out_valid), 32'd0);
    kill = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;

    // kill on CALC cycle 10
    issue(OP_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, model(OP_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D), 33);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    flush_last();
    chk("kill_in_ready", 32'(in_ready), 32'd1);
    chk("kill_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("kill_no_valid", 32'(seen), 32'd0);
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33); wait_idle(0);

    // reset mid-CALC
    issue(OP_MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 33);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    flush_last();
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out", out, 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    issue(OP_MUL, 32'd12345, 32'd678, 32'd8369910, 33); wait_idle(0);

    // Randomized ops with random output backpressure
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(o, a, b, model(o, a, b), model_lat(o, a, b));
      wait_idle(1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("drain_exp_q", 32'(exp_q.size()), 32'd0);
    chk("drain_count", 32'(done_n + flushed), 32'(issued));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
